// File: rtl/axis_pattern_gen.sv
// ---------------------------------------------------------------------------
// axis_pattern_gen
//
// AXI-Stream source that emits deterministic, self-describing byte-pattern
// packets. Byte k of packet p in a run carries (k + p) mod 256, so a sink can
// check ordering, loss and duplication from the received data alone.
//
// Ports
//   aclk, arst        clock (rising edge) and synchronous active-high reset
//   enable            level-sensitive start / continue
//   pkt_len           packet length in bytes (0 behaves as 1), latched in IDLE
//   pkt_count         packets per run (0 = until enable drops), latched in IDLE
//   dest              TDEST for the run, latched in IDLE
//   busy              high from run start until the FSM returns to IDLE
//   done              one-cycle pulse at run end
//   dbg_state         current FSM state (0 IDLE, 1 SEND, 2 DONE)
//   m_axis_*          AXI-Stream master (tvalid/tready/tdata/tkeep/tlast/
//                     tuser/tdest)
//
// Handshake: a beat transfers on a rising edge where tvalid & tready are both
// high. Once tvalid is raised, tvalid and every payload signal stay constant
// until that transfer; only reset withdraws tvalid. tready may be high before
// tvalid. A new beat is loaded in the same cycle the previous one transfers,
// so back-to-back beats and packets need no bubble.
// ---------------------------------------------------------------------------
module axis_pattern_gen #(
    parameter int          BUS_WIDTH  = 2,
    parameter int          USER_WIDTH = 1,
    parameter int          DEST_WIDTH = 1,
    parameter int          RAND_VALID = 0,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                   aclk,
    input  logic                   arst,
    input  logic                   enable,
    input  logic [15:0]            pkt_len,
    input  logic [15:0]            pkt_count,
    input  logic [DEST_WIDTH-1:0]  dest,
    output logic                   busy,
    output logic                   done,
    output logic [1:0]             dbg_state,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [BUS_WIDTH*8-1:0] m_axis_tdata,
    output logic [BUS_WIDTH-1:0]   m_axis_tkeep,
    output logic                   m_axis_tlast,
    output logic [USER_WIDTH-1:0]  m_axis_tuser,
    output logic [DEST_WIDTH-1:0]  m_axis_tdest
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;

    // Run configuration latched in IDLE
    logic [15:0]            r_len;
    logic [15:0]            r_count;
    logic [DEST_WIDTH-1:0]  r_dest;

    // Pointer to the next beat to load: byte offset within the packet and
    // packet index within the run.
    logic [15:0]            r_byte;
    logic [15:0]            r_pkt;

    logic [15:0]            r_lfsr;

    // Registered AXIS outputs
    logic                   r_tvalid;
    logic [BUS_WIDTH*8-1:0] r_tdata;
    logic [BUS_WIDTH-1:0]   r_tkeep;
    logic                   r_tlast;
    logic                   r_tfirst;

    logic                   w_hs;
    logic                   w_run_end;
    logic                   w_throttle;
    logic                   w_load;
    logic                   w_lfsr_fb;
    logic [BUS_WIDTH*8-1:0] w_beat_data;
    logic [BUS_WIDTH-1:0]   w_beat_keep;
    logic                   w_beat_last;
    logic                   w_beat_first;

    // Fibonacci LFSR, taps 16,14,13,11
    assign w_lfsr_fb  = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_throttle = (RAND_VALID == 0) || r_lfsr[0];

    assign w_hs = r_tvalid && m_axis_tready;

    // A run ends only at a tlast transfer: either the programmed count has
    // been reached (r_pkt was bumped when the last beat was loaded, so it
    // already holds the post-increment index) or enable has dropped.
    assign w_run_end = (r_state == ST_SEND) && w_hs && r_tlast &&
                       (((r_count != 16'd0) && (r_pkt == r_count)) || !enable);

    // Load a new beat when the output register is empty or is being emptied
    // this cycle; the throttle only gates fresh beats, never a held one.
    assign w_load = (r_state == ST_SEND) && (!r_tvalid || w_hs) &&
                    !w_run_end && w_throttle;

    // Build the beat at the load pointer
    always_comb begin : beat_build
        logic [16:0] v_k;
        w_beat_data = '0;
        w_beat_keep = '0;
        v_k         = '0;
        for (int i = 0; i < BUS_WIDTH; i++) begin
            v_k = {1'b0, r_byte} + 17'(i);
            if (v_k < {1'b0, r_len}) begin
                w_beat_keep[i]       = 1'b1;
                w_beat_data[i*8 +: 8] = v_k[7:0] + r_pkt[7:0];
            end
        end
    end

    // 17-bit compare so a 65535-byte packet cannot wrap the sum
    assign w_beat_last  = ({1'b0, r_byte} + 17'(BUS_WIDTH)) >= {1'b0, r_len};
    assign w_beat_first = (r_byte == 16'd0);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge aclk) begin
        if (arst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (enable)    w_next_state = ST_SEND;
            ST_SEND: if (w_run_end) w_next_state = ST_DONE;
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy      = (r_state != ST_IDLE);
        done      = (r_state == ST_DONE);
        dbg_state = r_state;
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge aclk) begin
        if (arst) begin
            r_len    <= 16'd1;
            r_count  <= '0;
            r_dest   <= '0;
            r_byte   <= '0;
            r_pkt    <= '0;
            r_lfsr   <= LFSR_SEED;
            r_tvalid <= 1'b0;
            r_tdata  <= '0;
            r_tkeep  <= '0;
            r_tlast  <= 1'b0;
            r_tfirst <= 1'b0;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
            case (r_state)
                ST_IDLE: begin
                    if (enable) begin
                        r_len   <= (pkt_len == 16'd0) ? 16'd1 : pkt_len;
                        r_count <= pkt_count;
                        r_dest  <= dest;
                        r_byte  <= '0;
                        r_pkt   <= '0;
                    end
                end
                ST_SEND: begin
                    if (w_hs) begin
                        r_tvalid <= 1'b0;
                        r_tdata  <= '0;
                        r_tkeep  <= '0;
                        r_tlast  <= 1'b0;
                        r_tfirst <= 1'b0;
                    end
                    if (w_load) begin
                        r_tvalid <= 1'b1;
                        r_tdata  <= w_beat_data;
                        r_tkeep  <= w_beat_keep;
                        r_tlast  <= w_beat_last;
                        r_tfirst <= w_beat_first;
                        if (w_beat_last) begin
                            r_byte <= '0;
                            r_pkt  <= r_pkt + 16'd1;  // wraps silently
                        end else begin
                            r_byte <= r_byte + 16'(BUS_WIDTH);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tkeep  = r_tkeep;
    assign m_axis_tlast  = r_tlast;
    assign m_axis_tdest  = r_dest;

    always_comb begin
        m_axis_tuser    = '0;
        m_axis_tuser[0] = r_tfirst;
    end

endmodule

// File: tb/tb_axis_pattern_gen.sv
// ---------------------------------------------------------------------------
// tb_axis_pattern_gen
//
// Two generator instances: u_dut (full rate) and u_dut_r (LFSR-throttled).
// Drivers push hand-computed beats into expected queues; negedge monitors pop
// and compare every transferred beat and check hold-stability while stalled.
// ---------------------------------------------------------------------------
module tb_axis_pattern_gen;

    localparam int W = 21;  // {tdata[15:0], tkeep[1:0], tlast, tuser, tdest}

    // ---------------- clock / reset ----------------
    logic aclk = 1'b0;
    always #5 aclk = ~aclk;
    logic arst;
    int   cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    // ---------------- DUT 0 (full rate) ----------------
    logic        en0, busy0, done0, tvalid0, tready0, tlast0;
    logic [15:0] len0, cnt0, tdata0;
    logic [0:0]  dest0, tuser0, tdest0;
    logic [1:0]  st0, tkeep0;

    axis_pattern_gen #(.BUS_WIDTH(2), .USER_WIDTH(1), .DEST_WIDTH(1),
                       .RAND_VALID(0), .LFSR_SEED(16'hACE1)) u_dut (
        .aclk(aclk), .arst(arst), .enable(en0), .pkt_len(len0),
        .pkt_count(cnt0), .dest(dest0), .busy(busy0), .done(done0),
        .dbg_state(st0), .m_axis_tvalid(tvalid0), .m_axis_tready(tready0),
        .m_axis_tdata(tdata0), .m_axis_tkeep(tkeep0), .m_axis_tlast(tlast0),
        .m_axis_tuser(tuser0), .m_axis_tdest(tdest0)
    );

    // ---------------- DUT R (throttled) ----------------
    logic        en_r, busy_r, done_r, tvalid_r, tready_r, tlast_r;
    logic [15:0] len_r, cnt_r, tdata_r;
    logic [0:0]  dest_r, tuser_r, tdest_r;
    logic [1:0]  st_r, tkeep_r;

    axis_pattern_gen #(.BUS_WIDTH(2), .USER_WIDTH(1), .DEST_WIDTH(1),
                       .RAND_VALID(1), .LFSR_SEED(16'hACE1)) u_dut_r (
        .aclk(aclk), .arst(arst), .enable(en_r), .pkt_len(len_r),
        .pkt_count(cnt_r), .dest(dest_r), .busy(busy_r), .done(done_r),
        .dbg_state(st_r), .m_axis_tvalid(tvalid_r), .m_axis_tready(tready_r),
        .m_axis_tdata(tdata_r), .m_axis_tkeep(tkeep_r), .m_axis_tlast(tlast_r),
        .m_axis_tuser(tuser_r), .m_axis_tdest(tdest_r)
    );

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_r_q[$];

    function automatic logic [W-1:0] beat(input logic [15:0] d, input logic [1:0] k,
                                          input logic l, input logic u, input logic dst);
        return {d, k, l, u, dst};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    // ---------------- monitor, DUT 0 ----------------
    int hs0 = 0, last_hs0 = -10, streak0 = 0;
    logic [W-1:0] cur0, prev0;
    logic prev_stall0 = 1'b0;

    always @(negedge aclk) begin
        cur0 = {tdata0, tkeep0, tlast0, tuser0, tdest0};
        if (arst) begin
            prev_stall0 = 1'b0;
        end else begin
            if (prev_stall0)
                check("hold0", {10'd0, tvalid0, cur0}, {10'd0, 1'b1, prev0});
            if (tvalid0 && tready0) begin
                hs0++;
                streak0  = (cyc == last_hs0 + 1) ? streak0 + 1 : 1;
                last_hs0 = cyc;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL beat0: got 0x%0h expected no beat", cur0);
                end else begin
                    check("beat0", {11'd0, cur0}, {11'd0, exp_q.pop_front()});
                end
            end
            prev_stall0 = tvalid0 && !tready0;
            prev0       = cur0;
        end
    end

    // ---------------- monitor, DUT R ----------------
    int hs_r = 0, last_hs_r = -10;
    logic [W-1:0] cur_r, prev_r;
    logic prev_stall_r = 1'b0;

    always @(negedge aclk) begin
        cur_r = {tdata_r, tkeep_r, tlast_r, tuser_r, tdest_r};
        if (arst) begin
            prev_stall_r = 1'b0;
        end else begin
            if (prev_stall_r)
                check("hold_r", {10'd0, tvalid_r, cur_r}, {10'd0, 1'b1, prev_r});
            if (tvalid_r && tready_r) begin
                hs_r++;
                last_hs_r = cyc;
                if (exp_r_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL beat_r: got 0x%0h expected no beat", cur_r);
                end else begin
                    check("beat_r", {11'd0, cur_r}, {11'd0, exp_r_q.pop_front()});
                end
            end
            prev_stall_r = tvalid_r && !tready_r;
            prev_r       = cur_r;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_done0(input int base, input int exp_hs, input int exp_streak);
        bit seen = 0;
        for (int t = 0; t < 400; t++) begin
            if (done0) begin
                seen = 1;
                break;
            end
            step();
        end
        en0 = 1'b0;
        if (!seen) begin
            n_cmp++;
            n_err++;
            $display("FAIL done0_timeout: got no done expected done within 400 cycles");
        end else begin
            check("done0_cycle", cyc, last_hs0 + 1);
            check("hs0_count", hs0 - base, exp_hs);
            if (exp_streak > 0) check("streak0", streak0, exp_streak);
            check("exp0_empty", exp_q.size(), 0);
            step();
            check("done0_pulse", {31'd0, done0}, 32'd0);
            check("busy0_fall", {31'd0, busy0}, 32'd0);
        end
    endtask

    task automatic run0(input logic [15:0] len, input logic [15:0] cnt, input logic dst,
                        input int exp_hs, input int exp_streak);
        int base;
        base  = hs0;
        len0  = len;
        cnt0  = cnt;
        dest0 = dst;
        en0   = 1'b1;
        step();
        // Changes outside IDLE must be ignored
        len0  = 16'd9;
        cnt0  = 16'd7;
        dest0 = ~dst;
        wait_done0(base, exp_hs, exp_streak);
    endtask

    task automatic wait_done_r(input int base, input int exp_hs);
        bit seen = 0;
        for (int t = 0; t < 3000; t++) begin
            tready_r = 1'($urandom_range(0, 1));
            if (done_r) begin
                seen = 1;
                break;
            end
            step();
        end
        en_r = 1'b0;
        if (!seen) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_r_timeout: got no done expected done within 3000 cycles");
        end else begin
            check("done_r_cycle", cyc, last_hs_r + 1);
            check("hs_r_count", hs_r - base, exp_hs);
            check("exp_r_empty", exp_r_q.size(), 0);
        end
    endtask

    task automatic push_r64();
        for (int n = 0; n < 32; n++)
            exp_r_q.push_back(beat({8'(2*n+1), 8'(2*n)}, 2'b11, n == 31, n == 0, 1'b0));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int base;
        arst = 1'b1;
        en0 = 0; len0 = 0; cnt0 = 0; dest0 = 0; tready0 = 1'b1;
        en_r = 0; len_r = 0; cnt_r = 0; dest_r = 0; tready_r = 1'b0;
        repeat (3) step();

        // Reset state
        check("rst_tvalid", {31'd0, tvalid0}, 32'd0);
        check("rst_tdata", {16'd0, tdata0}, 32'd0);
        check("rst_tkeep_last_user_dest", {27'd0, tkeep0, tlast0, tuser0, tdest0}, 32'd0);
        check("rst_busy_done", {30'd0, busy0, done0}, 32'd0);
        check("rst_state", {30'd0, st0}, 32'd0);
        check("rst_tvalid_r", {31'd0, tvalid_r}, 32'd0);
        arst = 1'b0;
        step();

        // len 5, count 1, dest 1
        exp_q.push_back(beat(16'h0100, 2'b11, 1'b0, 1'b1, 1'b1));
        exp_q.push_back(beat(16'h0302, 2'b11, 1'b0, 1'b0, 1'b1));
        exp_q.push_back(beat(16'h0004, 2'b01, 1'b1, 1'b0, 1'b1));
        run0(16'd5, 16'd1, 1'b1, 3, 3);

        // len 4, count 2: packets back-to-back
        exp_q.push_back(beat(16'h0100, 2'b11, 1'b0, 1'b1, 1'b0));
        exp_q.push_back(beat(16'h0302, 2'b11, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(beat(16'h0201, 2'b11, 1'b0, 1'b1, 1'b0));
        exp_q.push_back(beat(16'h0403, 2'b11, 1'b1, 1'b0, 1'b0));
        run0(16'd4, 16'd2, 1'b0, 4, 4);

        // len 0 (treated as 1), count 3
        exp_q.push_back(beat(16'h0000, 2'b01, 1'b1, 1'b1, 1'b0));
        exp_q.push_back(beat(16'h0001, 2'b01, 1'b1, 1'b1, 1'b0));
        exp_q.push_back(beat(16'h0002, 2'b01, 1'b1, 1'b1, 1'b0));
        run0(16'd0, 16'd3, 1'b0, 3, 3);

        // len 6, count 1, tready low for 5 cycles after tvalid rises
        exp_q.push_back(beat(16'h0100, 2'b11, 1'b0, 1'b1, 1'b0));
        exp_q.push_back(beat(16'h0302, 2'b11, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(beat(16'h0504, 2'b11, 1'b1, 1'b0, 1'b0));
        tready0 = 1'b0;
        len0 = 16'd6; cnt0 = 16'd1; dest0 = 1'b0; en0 = 1'b1;
        base = hs0;
        for (int t = 0; t < 20 && !tvalid0; t++) step();
        for (int i = 0; i < 5; i++) begin
            check("stall_tdata", {16'd0, tdata0}, 32'h0000_0100);
            check("stall_tvalid", {31'd0, tvalid0}, 32'd1);
            step();
        end
        tready0 = 1'b1;
        wait_done0(base, 3, 0);

        // count 0, len 2: enable dropped while packet 4 is stalled
        exp_q.push_back(beat(16'h0100, 2'b11, 1'b1, 1'b1, 1'b0));
        exp_q.push_back(beat(16'h0201, 2'b11, 1'b1, 1'b1, 1'b0));
        exp_q.push_back(beat(16'h0302, 2'b11, 1'b1, 1'b1, 1'b0));
        exp_q.push_back(beat(16'h0403, 2'b11, 1'b1, 1'b1, 1'b0));
        len0 = 16'd2; cnt0 = 16'd0; en0 = 1'b1;
        base = hs0;
        for (int t = 0; t < 100 && (hs0 - base) < 3; t++) step();
        tready0 = 1'b0;
        step();
        en0 = 1'b0;
        repeat (2) step();
        tready0 = 1'b1;
        wait_done0(base, 4, 0);
        repeat (3) step();
        check("no_pkt5", hs0 - base, 4);

        // Throttled: len 64, count 1, random tready
        push_r64();
        len_r = 16'd64; cnt_r = 16'd1; dest_r = 1'b0; en_r = 1'b1;
        base = hs_r;
        step();
        wait_done_r(base, 32);
        step();

        // Throttled: reset mid-packet, then restart from byte 0
        push_r64();
        en_r = 1'b1;
        base = hs_r;
        for (int t = 0; t < 1000 && (hs_r - base) < 5; t++) begin
            tready_r = 1'($urandom_range(0, 1));
            step();
        end
        arst = 1'b1;
        step();
        check("midrst_tvalid", {31'd0, tvalid_r}, 32'd0);
        check("midrst_busy", {31'd0, busy_r}, 32'd0);
        check("midrst_state", {30'd0, st_r}, 32'd0);
        arst = 1'b0;
        exp_r_q.delete();
        push_r64();
        base = hs_r;
        wait_done_r(base, 32);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/axis_pattern_gen.md
Name: axis_pattern_gen

Overview:
- Synthesizable AXI-Stream transmitter that generates deterministic, self-describing byte-pattern packets.
- It is the source-side counterpart to the stream sinks used around axis_tiny_fifo. It drives FIFO, width-converter and DMA paths in hardware and in benches without file stimulus.
- Packet length, packet count and TDEST are programmable. Optional LFSR throttling of TVALID exercises backpressure and bubble handling downstream.

Parameters:
- BUS_WIDTH, 2, TDATA width in bytes; byte 0 occupies tdata[7:0].
- USER_WIDTH, 1, TUSER width; bit 0 is used, other bits are driven 0.
- DEST_WIDTH, 1, TDEST width.
- RAND_VALID, 0, 1 enables LFSR gating of new-beat TVALID assertion.
- LFSR_SEED, 16'hACE1, reset value of the 16-bit Fibonacci LFSR (taps 16,14,13,11); must be nonzero.

Ports:
- aclk  in  1  sole clock, rising edge.
- arst  in  1  reset, synchronous, active-high.
- enable  in  1  start/continue generation; level sensitive.
- pkt_len  in  16  packet length in bytes; 0 is treated as 1.
- pkt_count  in  16  packets per run; 0 means run until enable drops.
- dest  in  DEST_WIDTH  TDEST value for the run.
- busy  out  1  high from run start until done.
- done  out  1  one-cycle pulse at run end.
- m_axis_tvalid  out  1  AXIS valid.
- m_axis_tready  in  1  AXIS ready.
- m_axis_tdata  out  BUS_WIDTH*8  AXIS data.
- m_axis_tkeep  out  BUS_WIDTH  AXIS byte enables.
- m_axis_tlast  out  1  last beat of packet.
- m_axis_tuser  out  USER_WIDTH  bit 0 = first beat of packet.
- m_axis_tdest  out  DEST_WIDTH  destination.

Behaviour:
- Reset values when arst is high at a clock edge:
  - State IDLE; all AXIS outputs 0; busy=0, done=0.
  - Byte counter, packet counter and packet index cleared; LFSR=LFSR_SEED.
  - Reset mid-packet drops tvalid the following cycle without completing the packet.
- States and transitions:
  - IDLE: on enable=1, latch pkt_len (0→1), pkt_count and dest; go to SEND; set busy=1.
  - First tvalid is seen no earlier than the cycle after the enable is sampled.
  - SEND: present beats. After the tlast handshake, the packet index increments:
    - If pkt_count≠0 and the index equals pkt_count → DONE.
    - Else if enable=0 → DONE.
    - Else the next packet's first beat may be presented the very next cycle (no forced gap).
  - Deasserting enable mid-packet never truncates a packet; the current packet finishes.
  - DONE: done=1 for exactly one cycle, busy=0 on exit, return to IDLE.
  - Re-run requires enable to be sampled in IDLE; if enable is still high, the new run starts immediately.
- Handshake:
  - A beat transfers when tvalid&tready.
  - Once tvalid=1, tvalid and all payload signals are held stable until the transfer; tvalid is never withdrawn except by reset.
  - tready is allowed high before tvalid.
- Throttle:
  - With RAND_VALID=1, the LFSR advances every cycle.
  - A new beat's tvalid asserts only in a cycle where LFSR bit 0 = 1.
  - With RAND_VALID=0, beats are back-to-back at full rate when tready=1.
- Data pattern:
  - Byte k of packet p (k from 0) = (k + p) mod 256, where p is the low 8 bits of the packet index within the run.
  - Beat n carries bytes n*BUS_WIDTH .. n*BUS_WIDTH+BUS_WIDTH-1.
- Last beat:
  - tlast=1 on beat ceil(len/BUS_WIDTH)-1.
  - tkeep = low (len mod BUS_WIDTH) bits set, or all ones if the remainder is 0.
  - Invalid bytes are driven 0x00.
  - All other beats have tkeep all ones and tlast=0.
- tuser[0]=1 only on the first beat of each packet; a 1-beat packet has both tuser[0] and tlast set.
- tdest = latched dest for the whole run.
- Counter widths:
  - Byte counter is 16 bits; len 65535 is supported.
  - Packet index is 16 bits; at pkt_count=0 it wraps 0xFFFF→0 silently.
- Inputs pkt_len, pkt_count and dest are ignored outside IDLE.

Test Plan:
- BUS_WIDTH=2, pkt_len=5, pkt_count=1, tready=1:
  - Beats 0x0100 (keep 11, user 1), 0x0302 (keep 11), 0x0004 (keep 01, last).
  - done pulses one cycle after the last handshake; busy falls.
- pkt_len=4, pkt_count=2:
  - Packet 0: 0x0100, 0x0302 (last, keep 11).
  - Packet 1: 0x0201, 0x0403 (last) on the immediately following cycles.
  - Exactly 4 handshakes, then done.
- pkt_len=0, pkt_count=3:
  - Three 1-beat packets with tdata 0x0000, 0x0001, 0x0002, each with keep 01, user 1, last 1.
- pkt_len=6, pkt_count=1, tready held 0 for 5 cycles after tvalid rises:
  - tdata=0x0100 and tvalid stay constant for all 5 cycles.
  - Stream then completes with beats 0x0302 and 0x0504 (last).
- pkt_count=0, enable high for 3 packets of pkt_len=2, then dropped mid-packet-4:
  - Packet 4 (tdata 0x0403, last) completes; done pulses; no packet 5.
- RAND_VALID=1, pkt_len=64, pkt_count=1, random tready:
  - Scoreboard sees bytes 0..63 in order with no loss or duplication.
  - tvalid never falls without a handshake.
  - Separately, assert arst mid-packet: tvalid=0 next cycle; busy=0; restart begins at byte 0.
